// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: command encodings, default I/O addresses,
// responder FSM state encoding and the latched request payload.
package mem_pkg;

    localparam int unsigned MEM_AW = 9;
    localparam int unsigned MEM_DW = 16;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned IO_W   = 8;

    // One-hot CPU memory commands
    localparam logic [CMD_W-1:0] MNONE  = 3'b001;
    localparam logic [CMD_W-1:0] MREAD  = 3'b010;
    localparam logic [CMD_W-1:0] MWRITE = 3'b100;

    localparam logic [MEM_AW-1:0] LED_ADDR_DEF = 9'h100;
    localparam logic [MEM_AW-1:0] SW_ADDR_DEF  = 9'h140;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        RESP  = 2'd2
    } resp_state_t;

    // Request captured at command acceptance
    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic              is_read;
    } mem_req_t;

    function automatic logic cmd_legal(input logic [CMD_W-1:0] cmd);
        return (cmd == MNONE) || (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous RAM with registered read.
//   clk   : clock
//   we    : write enable, writes wdata to addr on posedge
//   addr  : word address (read and write)
//   wdata : write data
//   rdata : registered read data of addr (old data on a same-edge write)
module mem_ram_sp #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU memory bus: data RAM, switch input port
// and LED output port behind a one-hot command interface.
//   clk, reset  : clock, synchronous active-high reset
//   mem_cmd     : one-hot command (MNONE/MREAD/MWRITE)
//   mem_addr    : word address; [8]=0 RAM, else I/O space
//   write_data  : store data, sampled with MWRITE
//   read_data   : registered read result, held until the next read completes
//   mem_ready   : one-cycle completion pulse for reads and writes
//   sw          : board switches (read at SW_ADDR)
//   led         : board LEDs (written at LED_ADDR)
//   cmd_err     : sticky illegal-command flag
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned       READ_LAT = 1,
    parameter int unsigned       RAM_AW   = 8,
    parameter logic [MEM_AW-1:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [MEM_AW-1:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  mem_cmd,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] write_data,
    output logic [MEM_DW-1:0] read_data,
    output logic              mem_ready,
    input  logic [IO_W-1:0]   sw,
    output logic [IO_W-1:0]   led,
    output logic              cmd_err
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

    resp_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    mem_req_t          req_q, req_next;

    logic              ram_we_c;
    logic [RAM_AW-1:0] ram_addr_c;
    logic [MEM_DW-1:0] ram_rdata;
    logic              led_we_c;
    logic              err_set_c;
    logic [MEM_DW-1:0] rdata_c;

    // Next-state, request latch and RAM/LED strobes
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_next   = req_q;
        ram_we_c   = 1'b0;
        ram_addr_c = req_q.addr[RAM_AW-1:0];
        led_we_c   = 1'b0;
        err_set_c  = 1'b0;
        unique case (state)
            IDLE: begin
                // LAT=1 reads sample the RAM at the acceptance edge itself
                ram_addr_c = mem_addr[RAM_AW-1:0];
                if (!cmd_legal(mem_cmd)) begin
                    err_set_c = 1'b1;
                end else if (mem_cmd == MREAD) begin
                    req_next   = '{addr: mem_addr, is_read: 1'b1};
                    cnt_next   = CNT_INIT;
                    state_next = (READ_LAT == 1) ? RESP : RWAIT;
                end else if (mem_cmd == MWRITE) begin
                    req_next   = '{addr: mem_addr, is_read: 1'b0};
                    ram_we_c   = ~mem_addr[MEM_AW-1];
                    led_we_c   = (mem_addr == LED_ADDR);
                    state_next = RESP;
                end
            end
            RWAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read-result source select from the latched address
    always_comb begin
        rdata_c = '0;
        if (!req_q.addr[MEM_AW-1]) begin
            rdata_c = ram_rdata;
        end else if (req_q.addr == SW_ADDR) begin
            rdata_c = MEM_DW'(sw);
        end
    end

    // FSM state, latency counter and latched request
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            req_q <= req_next;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data <= '0;
            mem_ready <= 1'b0;
            led       <= '0;
            cmd_err   <= 1'b0;
        end else begin
            mem_ready <= (state == RESP);
            if ((state == RESP) && req_q.is_read) begin
                read_data <= rdata_c;
            end
            if (led_we_c) begin
                led <= write_data[IO_W-1:0];
            end
            if (err_set_c) begin
                cmd_err <= 1'b1;
            end
        end
    end

    // Reset blocks a write presented on the same edge
    mem_ram_sp #(
        .WIDTH  (MEM_DW),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c & ~reset),
        .addr  (ram_addr_c),
        .wdata (write_data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: three instances (READ_LAT 1, 4, 3)
// share one stimulus stream; each instance's outputs are checked separately.
module tb_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mem_cmd = MNONE;
    logic [8:0]  mem_addr = '0;
    logic [15:0] write_data = '0;
    logic [7:0]  sw = '0;

    logic [15:0] rd0, rd1, rd2;
    logic        rdy0, rdy1, rdy2;
    logic [7:0]  led0, led1, led2;
    logic        err0, err1, err2;

    logic [15:0] obs_rd  [3];
    logic        obs_rdy [3];
    logic [7:0]  obs_led [3];
    logic        obs_err [3];

    int          lat [3] = '{1, 4, 3};

    int          rdy_cnt [3];
    int          rdy_cyc [3];
    logic [15:0] rdy_dat [3];
    logic [7:0]  led_c1  [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        obs_rd[0] = rd0;   obs_rd[1] = rd1;   obs_rd[2] = rd2;
        obs_rdy[0] = rdy0; obs_rdy[1] = rdy1; obs_rdy[2] = rdy2;
        obs_led[0] = led0; obs_led[1] = led1; obs_led[2] = led2;
        obs_err[0] = err0; obs_err[1] = err1; obs_err[2] = err2;
    end

    mem_responder #(.READ_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(rd0), .mem_ready(rdy0),
        .sw(sw), .led(led0), .cmd_err(err0)
    );
    mem_responder #(.READ_LAT(4)) dut1 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(rd1), .mem_ready(rdy1),
        .sw(sw), .led(led1), .cmd_err(err1)
    );
    mem_responder #(.READ_LAT(3)) dut2 (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(rd2), .mem_ready(rdy2),
        .sw(sw), .led(led2), .cmd_err(err2)
    );

    // Present one command for one edge, then observe 8 cycles (junk on the bus)
    task automatic run_cmd(input logic [2:0] cmd, input logic [8:0] addr,
                           input logic [15:0] wd);
        @(negedge clk);
        mem_cmd = cmd; mem_addr = addr; write_data = wd;
        @(posedge clk); #1;
        mem_cmd = MNONE; mem_addr = 9'h006; write_data = 16'h5A5A;
        for (int d = 0; d < 3; d++) begin
            rdy_cnt[d] = 0; rdy_cyc[d] = 0; rdy_dat[d] = 16'hDEAD;
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (c == 1) led_c1[d] = obs_led[d];
                if (obs_rdy[d]) begin
                    rdy_cnt[d]++; rdy_cyc[d] = c; rdy_dat[d] = obs_rd[d];
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({obs_rd[d], obs_rdy[d], obs_led[d], obs_err[d]} !== 26'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: rd=%h rdy=%b led=%h err=%b, want all 0",
                         d, obs_rd[d], obs_rdy[d], obs_led[d], obs_err[d]);
            end
        end
    endtask

    task automatic test_write_read();
        run_cmd(MWRITE, 9'h005, 16'hBEEF);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdy_cnt[d] !== 1 || rdy_cyc[d] !== 1) begin
                n_fail++;
                $display("FAIL write_ready dut%0d: pulses=%0d cyc=%0d, want 1 at 1",
                         d, rdy_cnt[d], rdy_cyc[d]);
            end
        end
        run_cmd(MREAD, 9'h005, 16'h0000);
        n_tests++;
        if (rdy_cnt[0] !== 1 || rdy_cyc[0] !== 1 || rdy_dat[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_lat1: pulses=%0d cyc=%0d data=%h, want 1 at 1 data beef",
                     rdy_cnt[0], rdy_cyc[0], rdy_dat[0]);
        end
    endtask

    task automatic test_latency();
        run_cmd(MWRITE, 9'h006, 16'h1111);
        run_cmd(MREAD, 9'h005, 16'h0000);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdy_cnt[d] !== 1 || rdy_cyc[d] !== lat[d] || rdy_dat[d] !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL latency dut%0d: pulses=%0d cyc=%0d data=%h, want 1 at %0d data beef",
                         d, rdy_cnt[d], rdy_cyc[d], rdy_dat[d], lat[d]);
            end
        end
    endtask

    task automatic test_led();
        run_cmd(MWRITE, LED_ADDR_DEF, 16'h12A5);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (led_c1[d] !== 8'hA5 || rdy_cnt[d] !== 1) begin
                n_fail++;
                $display("FAIL led_write dut%0d: led=%h pulses=%0d, want a5 and 1",
                         d, led_c1[d], rdy_cnt[d]);
            end
        end
        run_cmd(MREAD, LED_ADDR_DEF, 16'h0000);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdy_cnt[d] !== 1 || rdy_dat[d] !== 16'h0000) begin
                n_fail++;
                $display("FAIL led_read dut%0d: pulses=%0d data=%h, want 1 and 0000",
                         d, rdy_cnt[d], rdy_dat[d]);
            end
        end
    endtask

    task automatic test_switch();
        sw = 8'h3C;
        run_cmd(MREAD, SW_ADDR_DEF, 16'h0000);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdy_cnt[d] !== 1 || rdy_cyc[d] !== lat[d] || rdy_dat[d] !== 16'h003C) begin
                n_fail++;
                $display("FAIL sw_read dut%0d: pulses=%0d cyc=%0d data=%h, want 1 at %0d data 003c",
                         d, rdy_cnt[d], rdy_cyc[d], rdy_dat[d], lat[d]);
            end
        end
        run_cmd(MREAD, 9'h1FF, 16'h0000);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdy_cnt[d] !== 1 || rdy_dat[d] !== 16'h0000) begin
                n_fail++;
                $display("FAIL unmapped_read dut%0d: pulses=%0d data=%h, want 1 and 0000",
                         d, rdy_cnt[d], rdy_dat[d]);
            end
        end
    endtask

    task automatic test_cmd_err();
        run_cmd(3'b110, 9'h005, 16'h0000);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (obs_err[d] !== 1'b1 || rdy_cnt[d] !== 0) begin
                n_fail++;
                $display("FAIL illegal_cmd dut%0d: err=%b pulses=%0d, want 1 and 0",
                         d, obs_err[d], rdy_cnt[d]);
            end
        end
        run_cmd(3'b111, LED_ADDR_DEF, 16'h00FF);
        run_cmd(MREAD, 9'h005, 16'h0000);
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (rdy_dat[d] !== 16'hBEEF || obs_led[d] !== 8'hA5 || obs_err[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL err_sticky dut%0d: data=%h led=%h err=%b, want beef a5 1",
                         d, rdy_dat[d], obs_led[d], obs_err[d]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        seen = 0;
        @(negedge clk);
        mem_cmd = MREAD; mem_addr = 9'h005;
        @(posedge clk); #1;
        mem_cmd = MNONE; mem_addr = 9'h006;
        if (obs_rdy[2]) seen++;
        @(posedge clk); #1;
        if (obs_rdy[2]) seen++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_tests++;
        if (obs_rd[2] !== 16'h0000 || obs_rd[1] !== 16'h0000 || obs_err[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: rd2=%h rd1=%h err2=%b, want 0000 0000 0",
                     obs_rd[2], obs_rd[1], obs_err[2]);
        end
        for (int c = 0; c < 6; c++) begin
            if (obs_rdy[2] || obs_rdy[1]) seen++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_no_ready: ready pulses=%0d, want 0", seen);
        end
        run_cmd(MREAD, 9'h005, 16'h0000);
        for (int d = 1; d < 3; d++) begin
            n_tests++;
            if (rdy_cnt[d] !== 1 || rdy_cyc[d] !== lat[d] || rdy_dat[d] !== 16'hBEEF) begin
                n_fail++;
                $display("FAIL post_reset_read dut%0d: pulses=%0d cyc=%0d data=%h, want 1 at %0d data beef",
                         d, rdy_cnt[d], rdy_cyc[d], rdy_dat[d], lat[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_led();
        test_switch();
        test_cmd_err();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
